regfile_writer: RTL and testbench

Write side of the 32 x 32-bit register file. Accepts register write requests over a valid/ready handshake, buffers them in a 2-entry in-order write queue, and commits at most one entry per cycle into the register array. The array is exported as a flat 1024-bit bus that feeds the 32:1 read multiplexer. A pending-write query port lets the issue logic detect read-after-write hazards on writes that are still queued.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_wq.sv | 67 ++++++
 rtl/regfile_writer.sv | 85 ++++++++
 tb/tb_regfile_writer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// regfile_pkg
// Shared sizes and the write-request record for the register-file write side.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int NREGS = 32;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wq.sv
//------------------------------------------------------------------------------
// regfile_wq
// In-order write queue with valid/ready push, gated pop and per-entry taps.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  wr_req_t                   push_data,
  input  logic                      pop_en,
  output wr_req_t                   head,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          entry_valid,
  output logic [DEPTH-1:0][AW-1:0]  entry_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_req_t         r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign push_ready = (r_count < CW'(DEPTH)) && !rst;
  assign w_push     = push_valid && push_ready;
  assign w_pop      = pop_en && (r_count != '0);
  assign head       = r_mem[r_rd_ptr];
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    logic [PW-1:0] w_off;
    assign w_off          = PW'(i) - r_rd_ptr;
    assign entry_valid[i] = CW'(w_off) < r_count;
    assign entry_addr[i]  = r_mem[i].addr;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_writer.sv
//------------------------------------------------------------------------------
// regfile_writer
// Write side of the 32x32 register file: queued writes, array, hazard query.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_writer
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [AW-1:0]             wr_addr,
  input  logic [XLEN-1:0]           wr_data,
  input  logic                      commit_en,
  input  logic [AW-1:0]             q_addr,
  output logic                      q_pend,
  output logic [NREGS*XLEN-1:0]     regs_flat,
  output logic [$clog2(DEPTH):0]    q_count
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit c_zero_reg_en = 1'b1;
`else
  localparam bit c_zero_reg_en = 1'b0;
`endif

  wr_req_t                  w_req;
  wr_req_t                  w_head;
  logic                     w_commit;
  logic [NREGS-1:0]         w_dec;
  logic [DEPTH-1:0]         w_ent_valid;
  logic [DEPTH-1:0][AW-1:0] w_ent_addr;

  assign w_req = '{addr: wr_addr, data: wr_data};

  regfile_wq #(
    .DEPTH (DEPTH)
  ) u_wq (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (wr_valid),
    .push_ready  (wr_ready),
    .push_data   (w_req),
    .pop_en      (commit_en),
    .head        (w_head),
    .count       (q_count),
    .entry_valid (w_ent_valid),
    .entry_addr  (w_ent_addr)
  );

  assign w_commit = commit_en && (q_count != '0);
  assign w_dec    = w_commit ? (NREGS'(1) << w_head.addr) : '0;

  // The head entry still counts as pending on the edge it commits.
  always_comb begin
    q_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && (w_ent_addr[i] == q_addr) &&
          !(c_zero_reg_en && (q_addr == '0)))
        q_pend = 1'b1;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if ((i == 0) && c_zero_reg_en) begin : g_hard
      assign regs_flat[XLEN*i +: XLEN] = '0;
    end else begin : g_flop
      logic [XLEN-1:0] r_q;
      always_ff @(posedge clk) begin
        if (rst)           r_q <= '0;
        else if (w_dec[i]) r_q <= w_head.data;
      end
      assign regs_flat[XLEN*i +: XLEN] = r_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_writer.sv
//------------------------------------------------------------------------------
// tb_regfile_writer
// Scoreboard bench for regfile_writer (honours REGFILE_ZERO_REG_EN).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_writer;
  import regfile_pkg::*;

  localparam int DEPTH = 2;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  commit_en;
  logic [AW-1:0]         q_addr;
  logic                  q_pend;
  logic [NREGS*XLEN-1:0] regs_flat;
  logic [$clog2(DEPTH):0] q_count;

  int checks = 0;
  int errors = 0;

  wr_req_t         sb[$];
  logic [XLEN-1:0] mregs [NREGS];

  always #5 clk = ~clk;

  regfile_writer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .commit_en (commit_en),
    .q_addr    (q_addr),
    .q_pend    (q_pend),
    .regs_flat (regs_flat),
    .q_count   (q_count)
  );

  // One clock edge; the scoreboard follows the specified accept/commit rules.
  task automatic tick(output bit popped, output wr_req_t e);
    bit      acc;
    wr_req_t nw;
    acc    = wr_valid && !rst && (sb.size() < DEPTH);
    popped = !rst && commit_en && (sb.size() > 0);
    nw     = '{addr: wr_addr, data: wr_data};
    e      = '0;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      for (int i = 0; i < NREGS; i++) mregs[i] = '0;
      popped = 1'b0;
    end else begin
      if (popped) begin
        e = sb.pop_front();
        if (!(ZERO_EN && e.addr == '0)) mregs[e.addr] = e.data;
      end
      if (acc) sb.push_back(nw);
    end
    #1;
  endtask

  task automatic tick0();
    bit      p;
    wr_req_t e;
    tick(p, e);
  endtask

  function automatic logic [NREGS*XLEN-1:0] exp_flat();
    logic [NREGS*XLEN-1:0] f;
    for (int i = 0; i < NREGS; i++) f[XLEN*i +: XLEN] = mregs[i];
    return f;
  endfunction

  function automatic bit exp_pend(logic [AW-1:0] a);
    if (ZERO_EN && a == '0) return 1'b0;
    foreach (sb[i]) if (sb[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int first_diff(logic [NREGS*XLEN-1:0] a, logic [NREGS*XLEN-1:0] b);
    for (int i = 0; i < NREGS; i++) if (a[XLEN*i +: XLEN] !== b[XLEN*i +: XLEN]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    logic [NREGS*XLEN-1:0] ef;
    int d;
    rst = 1'b1; wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA5555;
    commit_en = 1'b1; q_addr = 5'd3;
    tick0(); tick0();
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", wr_ready); end
    checks++;
    if (q_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", q_count); end
    ef = '0; d = first_diff(regs_flat, ef);
    checks++;
    if (d >= 0) begin errors++; $display("FAIL reset_regs r%0d got %h want 0", d, regs_flat[XLEN*d +: XLEN]); end
    wr_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", wr_ready); end
  endtask

  task automatic test_single_write();
    bit p; wr_req_t e; int d;
    commit_en = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick(p, e);
    wr_valid = 1'b0; q_addr = 5'd5; #1;
    checks++;
    if (q_count !== 2'(sb.size())) begin errors++; $display("FAIL single_count got %0d want %0d", q_count, sb.size()); end
    checks++;
    if (q_pend !== exp_pend(5'd5)) begin errors++; $display("FAIL single_pend got %b want %b", q_pend, exp_pend(5'd5)); end
    tick(p, e);
    checks++;
    if (!p || regs_flat[191:160] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_r5 got %h want deadbeef (popped %b)", regs_flat[191:160], p);
    end
    d = first_diff(regs_flat, exp_flat());
    checks++;
    if (d >= 0) begin errors++; $display("FAIL single_regs r%0d got %h want %h", d, regs_flat[XLEN*d +: XLEN], mregs[d]); end
  endtask

  task automatic test_stall_fill();
    bit p; wr_req_t e;
    commit_en = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 32'h11111111; tick0();
    wr_addr = 5'd2; wr_data = 32'h22222222; tick0();
    wr_addr = 5'd3; wr_data = 32'h33333333; q_addr = 5'd2; #1;
    checks++;
    if (q_count !== 2'd2 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL stall_full count %0d ready %b want 2/0", q_count, wr_ready);
    end
    checks++;
    if (q_pend !== exp_pend(5'd2)) begin errors++; $display("FAIL stall_pend got %b want %b", q_pend, exp_pend(5'd2)); end
    tick0();
    wr_valid = 1'b0;
    checks++;
    if (q_count !== 2'(sb.size()) || regs_flat[32*1 +: 32] !== 32'h0) begin
      errors++; $display("FAIL stall_hold count %0d r1 %h want %0d/0", q_count, regs_flat[63:32], sb.size());
    end
    commit_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(p, e);
      checks++;
      if (!p || regs_flat[XLEN*e.addr +: XLEN] !== e.data || regs_flat[32*2 +: 32] !== mregs[2]) begin
        errors++; $display("FAIL stall_commit%0d r%0d got %h want %h r2 %h want %h", k, e.addr,
                           regs_flat[XLEN*e.addr +: XLEN], e.data, regs_flat[95:64], mregs[2]);
      end
    end
  endtask

  task automatic test_same_addr();
    bit p; wr_req_t e;
    commit_en = 1'b1; q_addr = 5'd7;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h1; tick0();
    wr_data = 32'h2; tick0();
    wr_valid = 1'b0; #1;
    checks++;
    if (q_pend !== 1'b1 || regs_flat[32*7 +: 32] !== 32'h1) begin
      errors++; $display("FAIL same_mid pend %b r7 %h want 1/00000001", q_pend, regs_flat[255:224]);
    end
    tick(p, e);
    checks++;
    if (regs_flat[32*7 +: 32] !== 32'h2 || q_pend !== 1'b0) begin
      errors++; $display("FAIL same_final r7 %h pend %b want 00000002/0", regs_flat[255:224], q_pend);
    end
  endtask

  task automatic test_back_to_back();
    bit p; wr_req_t e; int d;
    commit_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_valid = 1'b1;
      wr_addr  = 5'($urandom_range(8, 31));
      wr_data  = $urandom;
      tick(p, e);
      checks++;
      if (q_count !== 2'(sb.size()) || (p && regs_flat[XLEN*e.addr +: XLEN] !== e.data)) begin
        errors++; $display("FAIL b2b_%0d count %0d want %0d reg %h want %h", k, q_count, sb.size(),
                           regs_flat[XLEN*e.addr +: XLEN], e.data);
      end
    end
    wr_valid = 1'b0;
    tick0();
    d = first_diff(regs_flat, exp_flat());
    checks++;
    if (d >= 0 || q_count !== '0) begin
      errors++; $display("FAIL b2b_regs first diff r%0d count %0d want none/0", d, q_count);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    commit_en = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 32'hA0A0A0A0; tick0();
    wr_addr = 5'd11; wr_data = 32'hB1B1B1B1; tick0();
    wr_valid = 1'b0; rst = 1'b1; tick0();
    rst = 1'b0; commit_en = 1'b1; tick0(); tick0();
    d = first_diff(regs_flat, '0);
    checks++;
    if (d >= 0 || q_count !== '0) begin
      errors++; $display("FAIL reset_mid first nonzero r%0d count %0d want none/0", d, q_count);
    end
  endtask

  task automatic test_zero_reg();
    logic [XLEN-1:0] want;
    commit_en = 1'b0; q_addr = 5'd0;
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; tick0();
    wr_valid = 1'b0; #1;
    checks++;
    if (q_pend !== exp_pend(5'd0)) begin errors++; $display("FAIL zero_pend got %b want %b", q_pend, exp_pend(5'd0)); end
    commit_en = 1'b1; tick0();
    want = ZERO_EN ? 32'h0 : 32'hFFFFFFFF;
    checks++;
    if (regs_flat[31:0] !== want || q_count !== '0) begin
      errors++; $display("FAIL zero_r0 got %h count %0d want %h/0", regs_flat[31:0], q_count, want);
    end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) mregs[i] = '0;
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit_en = 1'b0; q_addr = '0;
    #1;
    test_reset();
    test_single_write();
    test_stall_fill();
    test_same_addr();
    test_back_to_back();
    test_reset_mid();
    test_zero_reg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
